mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter
Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-003 I_ARADDR  in  32  instruction-fetch read address, word aligned.
REQ-004 I_ARVALID  in  1  instruction read request.
REQ-005 I_ARREADY  out  1  instruction address accepted.
REQ-006 I_RDATA  out  32  instruction read data.
REQ-007 I_RVALID  out  1  instruction read data valid.
REQ-008 I_RREADY  in  1  instruction master accepts data.
REQ-009 D_ARWADDR  in  32  data-port shared read/write address.
REQ-010 D_AWVALID  in  1  data write address valid.
REQ-011 D_AWREADY  out  1  data write address accepted.
REQ-012 D_WDATA  in  32  data write payload.
REQ-013 D_WVALID  in  1  data write payload valid.
REQ-014 D_WREADY  out  1  data write payload accepted.
REQ-015 D_BVALID  out  1  data write response valid.
REQ-016 D_BREADY  in  1  data master accepts write response.
REQ-017 D_ARVALID  in  1  data read request.
REQ-018 D_ARREADY  out  1  data read address accepted.
REQ-019 D_RDATA  out  32  data read data.
REQ-020 D_RVALID  out  1  data read data valid.
REQ-021 D_RREADY  in  1  data master accepts read data.
REQ-022 S_ARWADDR  out  32  memory shared address; granted master's address, 0 in IDLE.
REQ-023 S_AWVALID  out  1  memory write address valid.
REQ-024 S_AWREADY  in  1  memory write address accepted.
REQ-025 S_WDATA  out  32  memory write payload.
REQ-026 S_WVALID  out  1  memory write payload valid.
REQ-027 S_WREADY  in  1  memory write payload accepted.
REQ-028 S_BVALID  in  1  memory write response valid.
REQ-029 S_BREADY  out  1  memory write response accepted.
REQ-030 S_ARVALID  out  1  memory read address valid.
REQ-031 S_ARREADY  in  1  memory read address accepted.
REQ-032 S_RDATA  in  32  memory read data.
REQ-033 S_RVALID  in  1  memory read data valid.
REQ-034 S_RREADY  out  1  memory read data accepted.
Function
REQ-035 FSM states IDLE, I_RD, D_RD, D_WR SHALL permit exactly one outstanding memory transaction; grant is taken only in IDLE, state changes on the next edge.
REQ-036 Arbitration SHALL be two-way round-robin: on simultaneous I/D requests, grant the master not granted last; within D, D_AWVALID wins over D_ARVALID; with a single requester, grant it.
REQ-037 In a granted state the granted master's valid/ready/data SHALL pass combinationally to/from S_* (zero added latency); all handshake outputs to the ungranted master and all S_* valid/ready outputs in IDLE SHALL be 0; S_RDATA broadcasts to I_RDATA and D_RDATA.
REQ-038 I_RD/D_RD SHALL exit to IDLE on the cycle S_RVALID&S_RREADY; D_WR SHALL track aw_done/w_done (AW and W complete in any order or same cycle), mask each valid after its handshake, and exit on S_BVALID&S_BREADY.
REQ-039 Request-to-S_*VALID latency SHALL be 1 cycle; back-to-back transactions SHALL have exactly one IDLE cycle between response handshake and next address valid.
REQ-040 Deasserting a master valid before its handshake SHALL be a protocol violation (no recovery required); masters hold address until response.
Reset
REQ-041 rst_n low SHALL immediately force state IDLE, last_grant=I (so D wins first tie), aw_done=w_done=0, all outputs 0; a mid-transaction reset abandons the transfer and the memory slave is reset with it.
Structure
REQ-042 Package mem_bus_pkg SHALL hold the 2-bit state encoding and grant-ID constants; design stays flat, no sub-module.
Verification
REQ-043 Reset: rst_n=0 asynchronously mid-D_WR -> all outputs 0 same cycle, IDLE after release.
REQ-044 I read alone, I_ARADDR=0x0000_0040, S_ARREADY next cycle, S_RDATA=0x2402_0005 two cycles later -> I_RDATA/I_RVALID match, IDLE one cycle after.
REQ-045 I_ARVALID and D_ARVALID both high from reset -> D granted first, then I; repeated ties alternate D,I,D,I.
REQ-046 D write 0xDEAD_BEEF to 0x0000_1004 with S_WREADY 3 cycles before S_AWREADY -> one AW, one W handshake, D_BVALID on S_BVALID, I untouched.
REQ-047 D_AWVALID and D_ARVALID together -> write completes before read; S_ARVALID never high during D_WR.

---
 rtl/mem_bus_pkg.sv | 14 +
 rtl/mem_bus_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared encodings for the two-master memory bus arbiter: FSM state and grant IDs.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_I_RD = 2'd1,
    ST_D_RD = 2'd2,
    ST_D_WR = 2'd3
  } state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter giving an instruction-read port and a data read/write port
// exclusive, one-transaction-at-a-time access to a single memory slave.
module mem_bus_arbiter
  import mem_bus_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] I_ARADDR,
  input  logic        I_ARVALID,
  output logic        I_ARREADY,
  output logic [31:0] I_RDATA,
  output logic        I_RVALID,
  input  logic        I_RREADY,
  input  logic [31:0] D_ARWADDR,
  input  logic        D_AWVALID,
  output logic        D_AWREADY,
  input  logic [31:0] D_WDATA,
  input  logic        D_WVALID,
  output logic        D_WREADY,
  output logic        D_BVALID,
  input  logic        D_BREADY,
  input  logic        D_ARVALID,
  output logic        D_ARREADY,
  output logic [31:0] D_RDATA,
  output logic        D_RVALID,
  input  logic        D_RREADY,
  output logic [31:0] S_ARWADDR,
  output logic        S_AWVALID,
  input  logic        S_AWREADY,
  output logic [31:0] S_WDATA,
  output logic        S_WVALID,
  input  logic        S_WREADY,
  input  logic        S_BVALID,
  output logic        S_BREADY,
  output logic        S_ARVALID,
  input  logic        S_ARREADY,
  input  logic [31:0] S_RDATA,
  input  logic        S_RVALID,
  output logic        S_RREADY
);

  state_t state_reg, state_next;
  logic   last_grant_reg, last_grant_next;
  logic   aw_done_reg, aw_done_next;
  logic   w_done_reg, w_done_next;
  logic   ar_done_reg, ar_done_next;
  logic   d_req;
  logic   grant_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      last_grant_reg <= GRANT_I;
      aw_done_reg    <= 1'b0;
      w_done_reg     <= 1'b0;
      ar_done_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      aw_done_reg    <= aw_done_next;
      w_done_reg     <= w_done_next;
      ar_done_reg    <= ar_done_next;
    end
  end

  // D wins a tie only when I was the previous grantee.
  assign d_req   = D_AWVALID | D_ARVALID;
  assign grant_d = d_req & (~I_ARVALID | (last_grant_reg == GRANT_I));

  // Read data is broadcast; held at zero while reset is asserted.
  assign I_RDATA = rst_n ? S_RDATA : 32'd0;
  assign D_RDATA = rst_n ? S_RDATA : 32'd0;

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    aw_done_next    = aw_done_reg;
    w_done_next     = w_done_reg;
    ar_done_next    = ar_done_reg;
    I_ARREADY       = 1'b0;
    I_RVALID        = 1'b0;
    D_AWREADY       = 1'b0;
    D_WREADY        = 1'b0;
    D_BVALID        = 1'b0;
    D_ARREADY       = 1'b0;
    D_RVALID        = 1'b0;
    S_ARWADDR       = 32'd0;
    S_AWVALID       = 1'b0;
    S_WDATA         = 32'd0;
    S_WVALID        = 1'b0;
    S_BREADY        = 1'b0;
    S_ARVALID       = 1'b0;
    S_RREADY        = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (grant_d) begin
          last_grant_next = GRANT_D;
          state_next      = D_AWVALID ? ST_D_WR : ST_D_RD;
        end else if (I_ARVALID) begin
          last_grant_next = GRANT_I;
          state_next      = ST_I_RD;
        end
      end

      ST_I_RD: begin
        S_ARWADDR = I_ARADDR;
        S_ARVALID = I_ARVALID & ~ar_done_reg;
        I_ARREADY = S_ARREADY & ~ar_done_reg;
        S_RREADY  = I_RREADY;
        I_RVALID  = S_RVALID;
        if (I_ARVALID && S_ARREADY && !ar_done_reg) ar_done_next = 1'b1;
        if (S_RVALID && I_RREADY) begin
          ar_done_next = 1'b0;
          state_next   = ST_IDLE;
        end
      end

      ST_D_RD: begin
        S_ARWADDR = D_ARWADDR;
        S_ARVALID = D_ARVALID & ~ar_done_reg;
        D_ARREADY = S_ARREADY & ~ar_done_reg;
        S_RREADY  = D_RREADY;
        D_RVALID  = S_RVALID;
        if (D_ARVALID && S_ARREADY && !ar_done_reg) ar_done_next = 1'b1;
        if (S_RVALID && D_RREADY) begin
          ar_done_next = 1'b0;
          state_next   = ST_IDLE;
        end
      end

      ST_D_WR: begin
        // AW and W complete independently; each is masked once accepted.
        S_ARWADDR = D_ARWADDR;
        S_WDATA   = D_WDATA;
        S_AWVALID = D_AWVALID & ~aw_done_reg;
        D_AWREADY = S_AWREADY & ~aw_done_reg;
        S_WVALID  = D_WVALID & ~w_done_reg;
        D_WREADY  = S_WREADY & ~w_done_reg;
        S_BREADY  = D_BREADY;
        D_BVALID  = S_BVALID;
        if (D_AWVALID && S_AWREADY && !aw_done_reg) aw_done_next = 1'b1;
        if (D_WVALID && S_WREADY && !w_done_reg) w_done_next = 1'b1;
        if (S_BVALID && D_BREADY) begin
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
          state_next   = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter; the memory slave is driven by hand each cycle.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        rst_n;
  logic [31:0] I_ARADDR;
  logic        I_ARVALID;
  logic        I_ARREADY;
  logic [31:0] I_RDATA;
  logic        I_RVALID;
  logic        I_RREADY;
  logic [31:0] D_ARWADDR;
  logic        D_AWVALID;
  logic        D_AWREADY;
  logic [31:0] D_WDATA;
  logic        D_WVALID;
  logic        D_WREADY;
  logic        D_BVALID;
  logic        D_BREADY;
  logic        D_ARVALID;
  logic        D_ARREADY;
  logic [31:0] D_RDATA;
  logic        D_RVALID;
  logic        D_RREADY;
  logic [31:0] S_ARWADDR;
  logic        S_AWVALID;
  logic        S_AWREADY;
  logic [31:0] S_WDATA;
  logic        S_WVALID;
  logic        S_WREADY;
  logic        S_BVALID;
  logic        S_BREADY;
  logic        S_ARVALID;
  logic        S_ARREADY;
  logic [31:0] S_RDATA;
  logic        S_RVALID;
  logic        S_RREADY;

  int errors = 0;
  int checks = 0;

  mem_bus_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .I_ARADDR(I_ARADDR), .I_ARVALID(I_ARVALID), .I_ARREADY(I_ARREADY),
    .I_RDATA(I_RDATA), .I_RVALID(I_RVALID), .I_RREADY(I_RREADY),
    .D_ARWADDR(D_ARWADDR), .D_AWVALID(D_AWVALID), .D_AWREADY(D_AWREADY),
    .D_WDATA(D_WDATA), .D_WVALID(D_WVALID), .D_WREADY(D_WREADY),
    .D_BVALID(D_BVALID), .D_BREADY(D_BREADY),
    .D_ARVALID(D_ARVALID), .D_ARREADY(D_ARREADY),
    .D_RDATA(D_RDATA), .D_RVALID(D_RVALID), .D_RREADY(D_RREADY),
    .S_ARWADDR(S_ARWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RDATA(S_RDATA), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    I_ARADDR = 0; I_ARVALID = 0; I_RREADY = 0;
    D_ARWADDR = 0; D_AWVALID = 0; D_WDATA = 0; D_WVALID = 0;
    D_BREADY = 0; D_ARVALID = 0; D_RREADY = 0;
    S_AWREADY = 0; S_WREADY = 0; S_BVALID = 0;
    S_ARREADY = 0; S_RDATA = 0; S_RVALID = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_handshakes"},
          {20'd0, I_ARREADY, I_RVALID, D_AWREADY, D_WREADY, D_BVALID, D_ARREADY,
           D_RVALID, S_AWVALID, S_WVALID, S_BREADY, S_ARVALID, S_RREADY}, 32'd0);
    check({tag, "_addr"}, S_ARWADDR, 32'd0);
    check({tag, "_wdata"}, S_WDATA, 32'd0);
    check({tag, "_irdata"}, I_RDATA, 32'd0);
    check({tag, "_drdata"}, D_RDATA, 32'd0);
  endtask

  logic exp_d [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Instruction read alone
    @(negedge clk);
    I_ARADDR = 32'h0000_0040; I_ARVALID = 1; I_RREADY = 1;
    #1 check("ird_idle_arvalid", S_ARVALID, 1'b0);
    check("ird_idle_addr", S_ARWADDR, 32'd0);
    @(negedge clk);
    S_ARREADY = 1;
    #1 check("ird_arvalid", S_ARVALID, 1'b1);
    check("ird_addr", S_ARWADDR, 32'h0000_0040);
    check("ird_arready", I_ARREADY, 1'b1);
    check("ird_d_arready", D_ARREADY, 1'b0);
    @(negedge clk);
    S_ARREADY = 0; I_ARVALID = 0;
    #1 check("ird_ar_dropped", S_ARVALID, 1'b0);
    check("ird_rvalid_early", I_RVALID, 1'b0);
    @(negedge clk);
    S_RVALID = 1; S_RDATA = 32'h2402_0005;
    #1 check("ird_rdata", I_RDATA, 32'h2402_0005);
    check("ird_rvalid", I_RVALID, 1'b1);
    check("ird_rready", S_RREADY, 1'b1);
    check("ird_d_rvalid", D_RVALID, 1'b0);
    check("ird_d_rdata_bcast", D_RDATA, 32'h2402_0005);
    @(negedge clk);
    S_RVALID = 0; S_RDATA = 0;
    #1 check("ird_back_idle_addr", S_ARWADDR, 32'd0);
    check("ird_back_idle_rvalid", I_RVALID, 1'b0);
    $display("txn I read addr=00000040 data=24020005");

    // Data write, W accepted three cycles before AW
    clear_inputs();
    D_ARWADDR = 32'h0000_1004; D_WDATA = 32'hDEAD_BEEF;
    D_AWVALID = 1; D_WVALID = 1; D_BREADY = 1;
    #1 check("wr_idle_awvalid", S_AWVALID, 1'b0);
    @(negedge clk);
    S_WREADY = 1;
    #1 check("wr_awvalid", S_AWVALID, 1'b1);
    check("wr_wvalid", S_WVALID, 1'b1);
    check("wr_wdata", S_WDATA, 32'hDEAD_BEEF);
    check("wr_addr", S_ARWADDR, 32'h0000_1004);
    check("wr_wready", D_WREADY, 1'b1);
    check("wr_awready_early", D_AWREADY, 1'b0);
    check("wr_i_arready", I_ARREADY, 1'b0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1 check("wr_w_masked", S_WVALID, 1'b0);
      check("wr_wready_masked", D_WREADY, 1'b0);
      check("wr_aw_pending", S_AWVALID, 1'b1);
    end
    @(negedge clk);
    S_AWREADY = 1;
    #1 check("wr_aw_hs", D_AWREADY, 1'b1);
    check("wr_aw_hs_valid", S_AWVALID, 1'b1);
    @(negedge clk);
    S_AWREADY = 0; S_WREADY = 0;
    #1 check("wr_aw_masked", S_AWVALID, 1'b0);
    check("wr_bvalid_early", D_BVALID, 1'b0);
    D_AWVALID = 0; D_WVALID = 0;
    @(negedge clk);
    S_BVALID = 1;
    #1 check("wr_bvalid", D_BVALID, 1'b1);
    check("wr_bready", S_BREADY, 1'b1);
    check("wr_i_rvalid", I_RVALID, 1'b0);
    @(negedge clk);
    S_BVALID = 0;
    #1 check("wr_idle_bready", S_BREADY, 1'b0);
    check("wr_idle_addr", S_ARWADDR, 32'd0);
    $display("txn D write addr=00001004 data=deadbeef");

    // Write and read requested together: write first, read after one idle cycle
    clear_inputs();
    D_ARWADDR = 32'h0000_2000; D_WDATA = 32'h1122_3344;
    D_AWVALID = 1; D_WVALID = 1; D_ARVALID = 1; D_BREADY = 1; D_RREADY = 1;
    @(negedge clk);
    S_AWREADY = 1; S_WREADY = 1;
    #1 check("wr_rd_awvalid", S_AWVALID, 1'b1);
    check("wr_rd_wvalid", S_WVALID, 1'b1);
    check("wr_rd_no_arvalid", S_ARVALID, 1'b0);
    check("wr_rd_no_arready", D_ARREADY, 1'b0);
    @(negedge clk);
    S_AWREADY = 0; S_WREADY = 0; D_AWVALID = 0; D_WVALID = 0; S_BVALID = 1;
    #1 check("wr_rd_bvalid", D_BVALID, 1'b1);
    check("wr_rd_no_arvalid2", S_ARVALID, 1'b0);
    @(negedge clk);
    S_BVALID = 0;
    #1 check("wr_rd_gap_arvalid", S_ARVALID, 1'b0);
    @(negedge clk);
    S_ARREADY = 1;
    #1 check("wr_rd_arvalid", S_ARVALID, 1'b1);
    check("wr_rd_arready", D_ARREADY, 1'b1);
    check("wr_rd_addr", S_ARWADDR, 32'h0000_2000);
    @(negedge clk);
    S_ARREADY = 0; D_ARVALID = 0; S_RVALID = 1; S_RDATA = 32'hCAFE_F00D;
    #1 check("wr_rd_rvalid", D_RVALID, 1'b1);
    check("wr_rd_rdata", D_RDATA, 32'hCAFE_F00D);
    check("wr_rd_i_rvalid", I_RVALID, 1'b0);
    @(negedge clk);
    S_RVALID = 0; S_RDATA = 0;
    #1 check("wr_rd_done", D_RVALID, 1'b0);
    $display("txn D write then read addr=00002000");

    // Asynchronous reset in the middle of a write
    clear_inputs();
    D_ARWADDR = 32'h0000_3000; D_WDATA = 32'h5555_AAAA;
    D_AWVALID = 1; D_WVALID = 1; D_BREADY = 1;
    @(negedge clk);
    #1 check("rst_mid_awvalid_before", S_AWVALID, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_mid");
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1 check_all_zero("rst_after");
    $display("txn reset during write");

    // Ties from reset alternate D, I, D, I
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    I_ARADDR = 32'h0000_0100; D_ARWADDR = 32'h0000_0200;
    I_RREADY = 1; D_RREADY = 1;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      I_ARVALID = 1; D_ARVALID = 1; S_RVALID = 0; S_ARREADY = 0;
      #1 check("tie_idle_arvalid", S_ARVALID, 1'b0);
      @(negedge clk);
      S_ARREADY = 1;
      #1 check("tie_addr", S_ARWADDR, exp_d[t] ? 32'h0000_0200 : 32'h0000_0100);
      check("tie_d_arready", D_ARREADY, exp_d[t]);
      check("tie_i_arready", I_ARREADY, !exp_d[t]);
      @(negedge clk);
      S_ARREADY = 0; S_RVALID = 1; S_RDATA = 32'h0000_1000 + t;
      #1 check("tie_d_rvalid", D_RVALID, exp_d[t]);
      check("tie_i_rvalid", I_RVALID, !exp_d[t]);
      $display("txn tie %0d granted %s", t, exp_d[t] ? "D" : "I");
    end
    @(negedge clk);
    clear_inputs();
    #1 check("final_idle", S_ARVALID, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
